multicycle_adder: RTL and testbench
===================================

Name: multicycle_adder

Overview:
- Parametrised, sequential successor to the 32-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands over WIDTH/DIGIT clock cycles, DIGIT bits per cycle. The carry is held in a register between slices.
- Uses valid/ready handshakes on both sides, and reports carry, signed overflow and zero flags.
- Sits between the register file / operand latches and the ALU result mux, where a full-width single-cycle carry chain is too slow.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be a multiple of DIGIT.
- DIGIT, 8, bits added per cycle. Must be between 1 and WIDTH inclusive.
- NSLICE, WIDTH/DIGIT, derived, not overridable. Number of compute cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in (add mode only).
- sub  input  1  0 = A+B+Cin; 1 = A-B (A + ~B + 1, Cin ignored).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- Result  output  WIDTH  sum/difference.
- Cout  output  1  carry out of the MSB (for sub: 1 = no borrow).
- Overflow  output  1  signed two's-complement overflow.
- Zero  output  1  Result == 0.

Behaviour:
- Reset (rst high at a clk edge):
  - state = IDLE; in_ready = 1; out_valid = 0.
  - Result = 0, Cout = 0, Overflow = 0, Zero = 0.
  - Slice counter = 0, carry register = 0.
  - Reset overrides every other input in the same cycle.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready at an edge:
    - latch A, latch B' = sub ? ~B : B.
    - carry register = sub ? 1 : Cin.
    - slice counter = 0; go to CALC.
  - Inputs are sampled only at this edge. Later changes on A/B/Cin/sub have no effect.
- CALC:
  - in_ready = 0, out_valid = 0.
  - Each cycle, slice i = counter:
    - {c, s} = A[i*DIGIT +: DIGIT] + B'[i*DIGIT +: DIGIT] + carry.
    - Result[i*DIGIT +: DIGIT] <= s; carry <= c; counter increments.
  - On the last slice (counter == NSLICE-1):
    - Cout <= c.
    - Overflow <= carry-into-MSB XOR carry-out-of-MSB, computed within the top slice.
    - Zero <= (final Result == 0).
    - Go to DONE.
  - Result bits are unspecified while in CALC. Only the values in DONE are architectural.
- DONE:
  - out_valid = 1; Result/Cout/Overflow/Zero are stable.
  - When out_ready is high at an edge: out_valid deasserts and the state returns to IDLE.
  - While out_ready is low, hold indefinitely with all outputs unchanged.
- Latency: if operands are accepted at edge k, out_valid is first high after edge k+NSLICE. With out_ready tied high, throughput is one operation per NSLICE+2 cycles.
- No overlap: in_ready is low throughout CALC and DONE, so in_valid is ignored there. A new operand pair can be accepted only in the IDLE cycle after the result is consumed.
- DIGIT == WIDTH: NSLICE = 1, so CALC lasts exactly one cycle.
- DIGIT == 1: bit-serial, WIDTH compute cycles.
- Wrap-around: the sum is taken modulo 2^WIDTH; any carry beyond the MSB appears only on Cout.
- Reset mid-operation (in CALC or DONE): abort, return to the reset values above, discard the pending result. There is no out_valid pulse for the aborted operation.
- No combinational path from any input to any output. All outputs are registered or decoded from state.

Test Plan:
- WIDTH=32, DIGIT=8: A=0x0000_00FF, B=0x0000_0001, Cin=0, sub=0.
  - Required: out_valid exactly 4 cycles after accept.
  - Result=0x0000_0100, Cout=0, Overflow=0, Zero=0. Carry crosses the slice boundary.
- Full carry chain: A=0xFFFF_FFFF, B=0x0000_0000, Cin=1.
  - Required: Result=0x0000_0000, Cout=1, Overflow=0, Zero=1.
- Signed overflow: A=0x7FFF_FFFF, B=0x0000_0001, add.
  - Required: Result=0x8000_0000, Overflow=1, Cout=0.
- Subtract with Cin ignored:
  - A=5, B=7, sub=1, Cin=1: Result=0xFFFF_FFFE, Cout=0, Overflow=0.
  - A=7, B=7, sub=1: Result=0, Cout=1, Zero=1.
- Back-pressure and reset:
  - Hold out_ready=0 for 10 cycles in DONE: outputs stable, in_ready=0, a new in_valid is ignored. Then out_ready=1: returns to IDLE.
  - Separately, assert rst in the 2nd CALC cycle: next cycle in_ready=1, out_valid=0, all flags 0, and no result is ever emitted.
- Parameter sweep, random 1000 operands per configuration, checked against a reference A+B+Cin / A-B model:
  - WIDTH=16/DIGIT=1 (latency 16).
  - WIDTH=32/DIGIT=32 (latency 1).
  - WIDTH=64/DIGIT=16 (latency 4).

Source files
------------

// File: rtl/multicycle_adder_if.sv
// Handshake and operand/result bundle for the multicycle adder.
// The slave modport is the adder side and the master modport is the producer/consumer side.
interface multicycle_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             Cout;
    logic             Overflow;
    logic             Zero;

    modport master (
        output in_valid, A, B, Cin, sub, out_ready,
        input  in_ready, out_valid, Result, Cout, Overflow, Zero
    );

    modport slave (
        input  in_valid, A, B, Cin, sub, out_ready,
        output in_ready, out_valid, Result, Cout, Overflow, Zero
    );
endinterface

// File: rtl/multicycle_adder.sv
// Sequential add/subtract unit that processes DIGIT bits per clock cycle.
// Operands are held in shift registers that move right by one slice each CALC cycle.
// Each new sum slice enters the result register from the top.
// After NSLICE cycles the result register holds the full result in its natural bit order.
// WIDTH must be a multiple of DIGIT, and 1 <= DIGIT <= WIDTH.
module multicycle_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_adder_if.slave    bus
);
    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [DIGIT:0]   sum_w;
    logic             c_into_msb;
    logic             last_slice;

    // Slice adder: the low DIGIT bits of the operand shift registers plus the held carry.
    // The carry into the slice MSB is recovered from the MSB sum bit: c_in = a ^ b ^ s.
    always_comb begin
        sum_w      = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        c_into_msb = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ sum_w[DIGIT-1];
        last_slice = (cnt_q == CNT_W'(NSLICE - 1));
    end

    // Next-state logic for the FSM, operand shift registers, result register and flags.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.A;
                    b_d     = bus.sub ? ~bus.B : bus.B;
                    carry_d = bus.sub ? 1'b1 : bus.Cin;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                result_d = (result_q >> DIGIT) | (WIDTH'(sum_w[DIGIT-1:0]) << (WIDTH - DIGIT));
                carry_d  = sum_w[DIGIT];
                cnt_d    = cnt_q + 1'b1;
                if (last_slice) begin
                    cout_d  = sum_w[DIGIT];
                    ovf_d   = c_into_msb ^ sum_w[DIGIT];
                    zero_d  = (result_d == '0);
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; a synchronous reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.Result    = result_q;
    assign bus.Cout      = cout_q;
    assign bus.Overflow  = ovf_q;
    assign bus.Zero      = zero_q;
endmodule

// File: tb/tb_multicycle_adder.sv
// Testbench for multicycle_adder.
// Instantiates four configurations: 32/8, 16/1, 32/32 and 64/16.
// The instance under test is chosen by sel, and results are compared with an arithmetic reference model.
module tb_multicycle_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  sel = 2'd0;
    logic        in_valid = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_ready = 1'b1;

    logic [63:0] res_a [4];
    logic        ir_a  [4];
    logic        ov_a  [4];
    logic        co_a  [4];
    logic        of_a  [4];
    logic        z_a   [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = (g == 1) ? 16 : (g == 3) ? 64 : 32;
        localparam int D = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 32 : 16;
        multicycle_adder_if #(.WIDTH(W)) bus ();
        assign bus.in_valid  = in_valid && (sel == 2'(g));
        assign bus.A         = a[W-1:0];
        assign bus.B         = b[W-1:0];
        assign bus.Cin       = cin;
        assign bus.sub       = sub;
        assign bus.out_ready = out_ready;
        assign res_a[g]      = 64'(bus.Result);
        assign ir_a[g]       = bus.in_ready;
        assign ov_a[g]       = bus.out_valid;
        assign co_a[g]       = bus.Cout;
        assign of_a[g]       = bus.Overflow;
        assign z_a[g]        = bus.Zero;
        multicycle_adder #(.WIDTH(W), .DIGIT(D)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    logic [63:0] res;
    logic        ir, ov, co, of, z;
    assign res = res_a[sel];
    assign ir  = ir_a[sel];
    assign ov  = ov_a[sel];
    assign co  = co_a[sel];
    assign of  = of_a[sel];
    assign z   = z_a[sel];

    function automatic int width_of(input int s);
        return (s == 1) ? 16 : (s == 3) ? 64 : 32;
    endfunction

    function automatic int nslice_of(input int s);
        return (s == 1) ? 16 : (s == 2) ? 1 : 4;
    endfunction

    // Reference model: plain unsigned/signed arithmetic on wide integers.
    function automatic void ref_model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                      input logic c, input logic sb,
                                      output logic [63:0] r, output logic co_r,
                                      output logic of_r, output logic z_r);
        logic [65:0] mask, ua, ub, us;
        logic signed [65:0] sa, sbv, ss, smax, smin;
        mask = (66'd1 << w) - 66'd1;
        ua   = {2'b00, av} & mask;
        ub   = {2'b00, bv} & mask;
        sa   = ua[w-1] ? $signed(ua | ~mask) : $signed(ua);
        sbv  = ub[w-1] ? $signed(ub | ~mask) : $signed(ub);
        smax = $signed(mask >> 1);
        smin = -smax - 66'sd1;
        if (sb) begin
            us   = ua - ub;
            co_r = (ua >= ub);
            ss   = sa - sbv;
        end else begin
            us   = ua + ub + {65'd0, c};
            co_r = us[w];
            ss   = sa + sbv;
            if (c) ss = ss + 66'sd1;
        end
        r    = us[63:0] & mask[63:0];
        of_r = (ss > smax) || (ss < smin);
        z_r  = (r == 64'd0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on the selected instance, with 'hold' cycles of back-pressure in DONE.
    task automatic run_op(input int s, input logic [63:0] av, input logic [63:0] bv,
                          input logic c, input logic sb, input int hold);
        logic [63:0] er;
        logic        eco, eof, ez;
        int          n;
        sel = 2'(s);
        #1;
        n = 0;
        while (!ir && n < 100) begin
            @(posedge clk); #1; n++;
        end
        a = av; b = bv; cin = c; sub = sb; in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = ~c; sub = ~sb;
        n = 0;
        while (!ov && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", 64'(n), 64'(nslice_of(s)));
        ref_model(width_of(s), av, bv, c, sb, er, eco, eof, ez);
        chk("result", res, er);
        chk("cout", 64'(co), 64'(eco));
        chk("overflow", 64'(of), 64'(eof));
        chk("zero", 64'(z), 64'(ez));
        repeat (hold) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("consumed_out_valid", 64'(ov), 64'd0);
        chk("consumed_in_ready", 64'(ir), 64'd1);
    endtask

    initial begin
        logic [63:0] snap;
        logic        snap_co, snap_of, snap_z;
        logic [63:0] ra, rb;
        int          pick;

        // Reset state on every instance.
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s); #1;
            chk("rst_in_ready", 64'(ir), 64'd1);
            chk("rst_out_valid", 64'(ov), 64'd0);
            chk("rst_result", res, 64'd0);
            chk("rst_flags", {61'd0, co, of, z}, 64'd0);
        end
        rst = 1'b0;

        // Directed cases on 32/8.
        run_op(0, 64'h0000_00FF, 64'h0000_0001, 1'b0, 1'b0, 0);
        chk("d_carry_slice", {res[31:0], 29'd0, co, of, z}, {32'h0000_0100, 32'd0});
        run_op(0, 64'hFFFF_FFFF, 64'h0, 1'b1, 1'b0, 0);
        chk("d_full_chain", {res[31:0], 29'd0, co, of, z}, {32'h0, 29'd0, 3'b101});
        run_op(0, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 0);
        chk("d_sovf", {res[31:0], 29'd0, co, of, z}, {32'h8000_0000, 29'd0, 3'b010});
        run_op(0, 64'd5, 64'd7, 1'b1, 1'b1, 0);
        chk("d_sub_neg", {res[31:0], 29'd0, co, of, z}, {32'hFFFF_FFFE, 29'd0, 3'b000});
        run_op(0, 64'd7, 64'd7, 1'b0, 1'b1, 0);
        chk("d_sub_eq", {res[31:0], 29'd0, co, of, z}, {32'h0, 29'd0, 3'b101});

        // Back-pressure: hold DONE for 10 cycles while a new request is presented.
        sel = 2'd0; a = 64'h1234_5678; b = 64'h1111_1111; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_valid_rises", 64'(ov), 64'd1);
        chk("bp_result", res, 64'h2345_6789);
        snap = res; snap_co = co; snap_of = of; snap_z = z;
        a = 64'hFFFF_0000; b = 64'h0000_FFFF; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 64'(ov), 64'd1);
            chk("bp_hold_in_ready", 64'(ir), 64'd0);
            chk("bp_hold_outputs", {res, 61'd0, co, of, z}, {snap, 61'd0, snap_co, snap_of, snap_z});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 64'(ov), 64'd0);
        chk("bp_release_in_ready", 64'(ir), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("bp_no_stray_op", {62'd0, ov, ir}, 64'd1);

        // Reset during the second CALC cycle aborts the operation.
        run_op(0, 64'hFFFF_FFFF, 64'h0, 1'b1, 1'b0, 0);
        a = 64'h7FFF_FFFF; b = 64'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", 64'(ir), 64'd1);
        chk("abort_out_valid", 64'(ov), 64'd0);
        chk("abort_result", res, 64'd0);
        chk("abort_flags", {61'd0, co, of, z}, 64'd0);
        pick = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ov) pick++;
        end
        chk("abort_no_emit", 64'(pick), 64'd0);

        // Randomised sweep over all configurations, with corner operands mixed in.
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < ((s == 0) ? 200 : 1000); i++) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                pick = $urandom_range(0, 9);
                if (pick == 0) ra = '1;
                if (pick == 1) rb = '0;
                if (pick == 2) begin ra = 64'h7FFF_FFFF_FFFF_FFFF >> (64 - width_of(s)); rb = 64'd1; end
                if (pick == 3) begin ra = 64'd1 << (width_of(s) - 1); rb = ra; end
                if (pick == 4) rb = ra;
                run_op(s, ra, rb, 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
